multicycle_control: RTL and testbench



---
 rtl/multicycle_control_pkg.sv | 45 ++++
 rtl/multicycle_control_perf_counters.sv | 29 ++
 rtl/multicycle_control.sv | 171 +++++++++++++++++
 tb/tb_multicycle_control.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32 subset controller.
// States, opcodes and datapath mux selects live here so the controller and its helpers agree.
package multicycle_control_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_REG   = 2'd1;
    localparam logic [1:0] SRC_A_OLDPC = 2'd2;

    localparam logic [1:0] SRC_B_REG  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/multicycle_control_perf_counters.sv
// Free-running cycle and retired-instruction counters, both wrapping at 2^32.
// Latency: counts visible the cycle after the qualifying cycle.
// Backpressure: none; pure observers of controller activity.
module perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        active_i,
    input  logic        retire_i,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_o
);

    logic [31:0] cycle_cnt_q;
    logic [31:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= 32'd0;
            instret_q   <= 32'd0;
        end else begin
            if (active_i) cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (retire_i) instret_q   <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instret_o   = instret_q;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer for LD/SD/R-type/BEQ/BNE; drives every datapath select and write-enable.
// Latency: outputs are combinational from state; LD 5, SD 4, R 4, branch 3, illegal 2 cycles.
// Backpressure: FETCH/MEM_READ/MEM_WRITE hold until mem_ready_i. PERF_CNT_EN adds perf counters.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       i_or_d_o,
    output logic       ir_we_o,
    output logic       mdr_we_o,
    output logic       pc_we_o,
    output logic       pc_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       reg_we_o,
    output logic       mem_to_reg_o,
    output logic       illegal_o,
    output logic [3:0] state_o
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_o
`endif
);

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        i_or_d_o     = 1'b0;
        ir_we_o      = 1'b0;
        mdr_we_o     = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = PC_SRC_ALU;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_REG;
        alu_op_o     = ALU_ADD;
        reg_we_o     = 1'b0;
        mem_to_reg_o = 1'b0;
        illegal_o    = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;

            FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_a_o = SRC_A_PC;
                alu_src_b_o = SRC_B_FOUR;
                alu_op_o    = ALU_ADD;
                if (mem_ready_i) begin
                    ir_we_o  = 1'b1;
                    pc_we_o  = 1'b1;
                    pc_src_o = PC_SRC_ALU;
                    state_d  = DECODE;
                end
            end

            // ALUOut captures OLDPC + imm so BRANCH can steer it into PC.
            DECODE: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_ADD;
                if (is_mem_op(opcode_i))         state_d = MEM_ADDR;
                else if (opcode_i == OPC_RTYPE)  state_d = EXECUTE;
                else if (opcode_i == OPC_BRANCH) state_d = BRANCH;
                else begin
                    illegal_o = 1'b1;
                    state_d   = FETCH;
                end
            end

            MEM_ADDR: begin
                alu_src_a_o = SRC_A_REG;
                alu_src_b_o = SRC_B_IMM;
                alu_op_o    = ALU_ADD;
                state_d     = (opcode_i == OPC_STORE) ? MEM_WRITE : MEM_READ;
            end

            MEM_READ: begin
                mem_req_o = 1'b1;
                i_or_d_o  = 1'b1;
                if (mem_ready_i) begin
                    mdr_we_o = 1'b1;
                    state_d  = MEM_WB;
                end
            end

            MEM_WB: begin
                reg_we_o     = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = FETCH;
            end

            MEM_WRITE: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                i_or_d_o  = 1'b1;
                if (mem_ready_i) state_d = FETCH;
            end

            EXECUTE: begin
                alu_src_a_o = SRC_A_REG;
                alu_src_b_o = SRC_B_REG;
                alu_op_o    = ALU_FUNCT;
                state_d     = ALU_WB;
            end

            ALU_WB: begin
                reg_we_o     = 1'b1;
                mem_to_reg_o = 1'b0;
                state_d      = FETCH;
            end

            BRANCH: begin
                alu_src_a_o = SRC_A_REG;
                alu_src_b_o = SRC_B_REG;
                alu_op_o    = ALU_SUB;
                pc_src_o    = PC_SRC_ALUOUT;
                case (funct3_i)
                    F3_BEQ:  pc_we_o = zero_i;
                    F3_BNE:  pc_we_o = ~zero_i;
                    default: illegal_o = 1'b1;
                endcase
                state_d = FETCH;
            end

            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;

`ifdef PERF_CNT_EN
    logic retire;

    always_comb begin
        retire = 1'b0;
        case (state_q)
            MEM_WB, ALU_WB: retire = 1'b1;
            MEM_WRITE:      retire = mem_ready_i;
            BRANCH:         retire = ~illegal_o;
            default:        retire = 1'b0;
        endcase
    end

    perf_counters u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .active_i    (state_q != IDLE),
        .retire_i    (retire),
        .cycle_cnt_o (cycle_cnt_o),
        .instret_o   (instret_o)
    );
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control vectors go through a scoreboard queue.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, iord, irwe, mdrwe, pcwe, pcsrc;
        logic [1:0] a, b, op;
        logic       regwe, m2r, ill;
    } ctl_t;

    function automatic ctl_t mk(input logic [3:0] st, input logic req, input logic we,
                                input logic iord, input logic irwe, input logic mdrwe,
                                input logic pcwe, input logic pcsrc, input logic [1:0] a,
                                input logic [1:0] b, input logic [1:0] op, input logic regwe,
                                input logic m2r, input logic ill);
        return {st, req, we, iord, irwe, mdrwe, pcwe, pcsrc, a, b, op, regwe, m2r, ill};
    endfunction

    //                               st   req we iod irw mdr pcw pcs a     b     op    rw m2r ill
    localparam ctl_t C_IDLE      = mk(4'd0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    localparam ctl_t C_FETCH_W   = mk(4'd1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 0, 0, 0);
    localparam ctl_t C_FETCH_R   = mk(4'd1, 1, 0, 0, 1, 0, 1, 0, 2'd0, 2'd1, 2'd0, 0, 0, 0);
    localparam ctl_t C_DECODE    = mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 2'd0, 0, 0, 0);
    localparam ctl_t C_DECODE_IL = mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 2'd0, 0, 0, 1);
    localparam ctl_t C_MEM_ADDR  = mk(4'd3, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 0, 0, 0);
    localparam ctl_t C_MEM_RD_R  = mk(4'd4, 1, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    localparam ctl_t C_MEM_WB    = mk(4'd5, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 1, 0);
    localparam ctl_t C_MEM_WR    = mk(4'd6, 1, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0);
    localparam ctl_t C_EXECUTE   = mk(4'd7, 0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd2, 0, 0, 0);
    localparam ctl_t C_ALU_WB    = mk(4'd8, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 0, 0);
    localparam ctl_t C_BR_TAKEN  = mk(4'd9, 0, 0, 0, 0, 0, 1, 1, 2'd1, 2'd0, 2'd1, 0, 0, 0);
    localparam ctl_t C_BR_NOT    = mk(4'd9, 0, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd1, 0, 0, 0);
    localparam ctl_t C_BR_ILL    = mk(4'd9, 0, 0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd1, 0, 0, 1);

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_XX = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode_i;
    logic [2:0] funct3_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       mem_req_o, mem_we_o, i_or_d_o, ir_we_o, mdr_we_o, pc_we_o, pc_src_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o;
    logic       reg_we_o, mem_to_reg_o, illegal_o;
    logic [3:0] state_o;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_o, instret_o;
`endif

    int   tests = 0;
    int   fails = 0;
    ctl_t exp_q[$];

    multicycle_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode_i     (opcode_i),
        .funct3_i     (funct3_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .i_or_d_o     (i_or_d_o),
        .ir_we_o      (ir_we_o),
        .mdr_we_o     (mdr_we_o),
        .pc_we_o      (pc_we_o),
        .pc_src_o     (pc_src_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .reg_we_o     (reg_we_o),
        .mem_to_reg_o (mem_to_reg_o),
        .illegal_o    (illegal_o),
        .state_o      (state_o)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt_o  (cycle_cnt_o),
        .instret_o    (instret_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic ctl_t observed();
        return {state_o, mem_req_o, mem_we_o, i_or_d_o, ir_we_o, mdr_we_o, pc_we_o, pc_src_o,
                alu_src_a_o, alu_src_b_o, alu_op_o, reg_we_o, mem_to_reg_o, illegal_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue the expected vector, compare it on the falling edge.
    task automatic cyc(input string tag, input logic rdy, input logic z, input ctl_t e);
        ctl_t got, exp;
        mem_ready_i = rdy;
        zero_i      = z;
        exp_q.push_back(e);
        @(negedge clk);
        got = observed();
        exp = exp_q.pop_front();
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input string tag);
        opcode_i = OP_R;
        cyc({tag, "_fetch"}, 1'b1, 1'b0, C_FETCH_R);
        cyc({tag, "_decode"}, 1'b1, 1'b0, C_DECODE);
        cyc({tag, "_exec"}, 1'b1, 1'b0, C_EXECUTE);
        cyc({tag, "_wb"}, 1'b1, 1'b0, C_ALU_WB);
    endtask

    task automatic branch(input string tag, input logic [2:0] f3, input logic z, input ctl_t e);
        opcode_i = OP_BR;
        funct3_i = f3;
        // zero_i deliberately opposite outside BRANCH: only the BRANCH cycle may matter.
        cyc({tag, "_fetch"}, 1'b1, ~z, C_FETCH_R);
        cyc({tag, "_decode"}, 1'b1, ~z, C_DECODE);
        cyc({tag, "_branch"}, 1'b1, z, e);
    endtask

    initial begin
        rst_n       = 1'b0;
        opcode_i    = 7'd0;
        funct3_i    = 3'd0;
        zero_i      = 1'b0;
        mem_ready_i = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset_state", 1'b1, 1'b0, C_IDLE);
        rst_n = 1'b1;
        cyc("idle_after_reset", 1'b0, 1'b0, C_IDLE);

        opcode_i = OP_LD;
        cyc("ld_fetch", 1'b1, 1'b0, C_FETCH_R);
        cyc("ld_decode", 1'b1, 1'b0, C_DECODE);
        cyc("ld_addr", 1'b1, 1'b0, C_MEM_ADDR);
        cyc("ld_read", 1'b1, 1'b0, C_MEM_RD_R);
        cyc("ld_wb", 1'b1, 1'b0, C_MEM_WB);

        opcode_i = OP_SD;
        cyc("sd_fetch", 1'b1, 1'b0, C_FETCH_R);
        cyc("sd_decode", 1'b0, 1'b0, C_DECODE);
        cyc("sd_addr", 1'b0, 1'b0, C_MEM_ADDR);
        for (int i = 0; i < 3; i++) cyc("sd_write_wait", 1'b0, 1'b0, C_MEM_WR);
        cyc("sd_write_done", 1'b1, 1'b0, C_MEM_WR);

        rtype("r0");

        branch("beq_z1", 3'b000, 1'b1, C_BR_TAKEN);
        branch("beq_z0", 3'b000, 1'b0, C_BR_NOT);
        branch("bne_z1", 3'b001, 1'b1, C_BR_NOT);
        branch("bne_z0", 3'b001, 1'b0, C_BR_TAKEN);

        opcode_i = OP_XX;
        cyc("ill_fetch", 1'b1, 1'b0, C_FETCH_R);
        cyc("ill_decode", 1'b1, 1'b0, C_DECODE_IL);
        opcode_i = OP_R;
        cyc("ill_next_fetch", 1'b1, 1'b0, C_FETCH_R);
        cyc("ill_next_decode", 1'b1, 1'b0, C_DECODE);
        cyc("ill_next_exec", 1'b1, 1'b0, C_EXECUTE);
        cyc("ill_next_wb", 1'b1, 1'b0, C_ALU_WB);

        branch("br_f3_010", 3'b010, 1'b1, C_BR_ILL);

        // Reset asserted asynchronously in the middle of a stalled fetch.
        opcode_i = OP_LD;
        cyc("fetch_wait0", 1'b0, 1'b0, C_FETCH_W);
        cyc("fetch_wait1", 1'b0, 1'b0, C_FETCH_W);
        mem_ready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("async_rst_state", {28'd0, state_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef PERF_CNT_EN
        chk("perf_cycle_reset", cycle_cnt_o, 32'd0);
        chk("perf_instret_reset", instret_o, 32'd0);
`endif
        cyc("post_rst_idle", 1'b1, 1'b0, C_IDLE);
        rtype("r1");
        rtype("r2");
        rtype("r3");
`ifdef PERF_CNT_EN
        chk("perf_cycle_3r", cycle_cnt_o, 32'd12);
        chk("perf_instret_3r", instret_o, 32'd3);
        force dut.u_perf.cycle_cnt_q = 32'hFFFF_FFFD;
        force dut.u_perf.instret_q   = 32'hFFFF_FFFF;
        #1;
        release dut.u_perf.cycle_cnt_q;
        release dut.u_perf.instret_q;
        rtype("r_wrap");
        chk("perf_cycle_wrap", cycle_cnt_o, 32'd1);
        chk("perf_instret_wrap", instret_o, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
